// File: rtl/flappy_pkg.sv
// Shared constants for the bird motion controller.
// Holds the state encoding, geometry and physics defaults.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DEAD  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int SCREEN_H = 480;
  localparam int BIRD_H   = 16;
  localparam int FLAP_V   = 8;
  localparam int GRAVITY  = 1;
  localparam int VMAX     = 10;

  // Signed width able to hold -fv .. vm+gravity headroom.
  function automatic int vel_bits(int fv, int vm);
    int m;
    m = (fv > vm + 1) ? fv : vm + 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/bird_physics.sv
// Per-frame next velocity / next position for the bird.
// y is clamped to the ceiling and ground rows; vel_n is pre-contact.
module bird_physics #(
  parameter int Y_W     = 10,
  parameter int VEL_W   = 5,
  parameter int Y_GND   = 464,
  parameter int FLAP_V  = 8,
  parameter int GRAVITY = 1,
  parameter int VMAX    = 10
)(
  input  logic [Y_W-1:0]          i_y,
  input  logic signed [VEL_W-1:0] i_vel,
  input  logic                    i_flap,
  output logic [Y_W-1:0]          o_y,
  output logic signed [VEL_W-1:0] o_vel,
  output logic                    o_ceil_hit,
  output logic                    o_ground_hit
);

  localparam int EW = Y_W + 2;
  localparam logic signed [EW-1:0] C_GRAV = EW'(GRAVITY);
  localparam logic signed [EW-1:0] C_VMAX = EW'(VMAX);
  localparam logic signed [EW-1:0] C_FLAP = EW'(FLAP_V);
  localparam logic signed [EW-1:0] C_GND  = EW'(Y_GND);

  logic signed [EW-1:0] w_vel_x;
  logic signed [EW-1:0] w_vel_g;
  logic signed [EW-1:0] w_vel_n;
  logic signed [EW-1:0] w_y_x;
  logic signed [EW-1:0] w_y_n;

  assign w_vel_x = EW'(i_vel);
  assign w_vel_g = w_vel_x + C_GRAV;
  assign w_vel_n = i_flap ? -C_FLAP :
                   (w_vel_g > C_VMAX) ? C_VMAX : w_vel_g;

  assign w_y_x = {2'b00, i_y};
  assign w_y_n = w_y_x + w_vel_n;

  assign o_ceil_hit   = w_y_n[EW-1];
  assign o_ground_hit = !w_y_n[EW-1] && (w_y_n >= C_GND);

  always_comb begin
    o_y = w_y_n[Y_W-1:0];
    if (o_ceil_hit)   o_y = '0;
    if (o_ground_hit) o_y = Y_W'(Y_GND);
  end

  assign o_vel = w_vel_n[VEL_W-1:0];

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird game FSM: flap latch, per-frame physics, scoring.
// Define BIRD_PAUSE_EN to let start toggle PLAY <-> PAUSE.
module bird_motion_ctrl
  import flappy_pkg::*;
#(
  parameter int Y_W      = 10,
  parameter int SCREEN_H = flappy_pkg::SCREEN_H,
  parameter int BIRD_H   = flappy_pkg::BIRD_H,
  parameter int Y_START  = 240,
  parameter int FLAP_V   = flappy_pkg::FLAP_V,
  parameter int GRAVITY  = flappy_pkg::GRAVITY,
  parameter int VMAX     = flappy_pkg::VMAX,
  parameter int SCORE_W  = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flap,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               hit,
  input  logic               pipe_pass,
  output logic [Y_W-1:0]     bird_y,
  output logic [1:0]         state,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);

  localparam int VEL_W = vel_bits(FLAP_V, VMAX);
  localparam logic [Y_W-1:0] C_Y0 = Y_W'(Y_START);
  localparam logic [SCORE_W-1:0] C_SMAX = '1;

  state_t                  r_state, w_state_n;
  logic [Y_W-1:0]          r_y, w_y_n, w_phy_y;
  logic signed [VEL_W-1:0] r_vel, w_vel_n, w_phy_vel;
  logic                    r_pend, w_pend_n, w_pend_any;
  logic                    w_ceil, w_ground;
  logic [SCORE_W-1:0]      r_score, w_score_n;

  // A flap arriving with the tick still counts for that tick.
  assign w_pend_any = r_pend | flap;

  bird_physics #(
    .Y_W     (Y_W),
    .VEL_W   (VEL_W),
    .Y_GND   (SCREEN_H - BIRD_H),
    .FLAP_V  (FLAP_V),
    .GRAVITY (GRAVITY),
    .VMAX    (VMAX)
  ) u_phy (
    .i_y          (r_y),
    .i_vel        (r_vel),
    .i_flap       (w_pend_any),
    .o_y          (w_phy_y),
    .o_vel        (w_phy_vel),
    .o_ceil_hit   (w_ceil),
    .o_ground_hit (w_ground)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_y     <= C_Y0;
      r_vel   <= '0;
      r_pend  <= 1'b0;
      r_score <= '0;
    end else begin
      r_state <= w_state_n;
      r_y     <= w_y_n;
      r_vel   <= w_vel_n;
      r_pend  <= w_pend_n;
      r_score <= w_score_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_y_n     = r_y;
    w_vel_n   = r_vel;
    w_pend_n  = r_pend;
    w_score_n = r_score;
    unique case (r_state)
      ST_IDLE: begin
        w_y_n    = C_Y0;
        w_vel_n  = '0;
        w_pend_n = 1'b0;
        if (start) begin
          w_state_n = ST_PLAY;
          w_score_n = '0;
        end
      end
      ST_PLAY: begin
        if (hit) begin
          w_state_n = ST_DEAD;
`ifdef BIRD_PAUSE_EN
        end else if (start) begin
          w_state_n = ST_PAUSE;
          w_pend_n  = 1'b0;
`endif
        end else begin
          w_pend_n = w_pend_any;
          if (frame_tick) begin
            w_y_n    = w_phy_y;
            w_vel_n  = (w_ceil || w_ground) ? '0 : w_phy_vel;
            w_pend_n = 1'b0;
            if (w_ground) w_state_n = ST_DEAD;
          end
          if (pipe_pass && r_score != C_SMAX &&
              !(frame_tick && w_ground))
            w_score_n = r_score + 1'b1;
        end
      end
      ST_DEAD: begin
        if (start) begin
          w_state_n = ST_IDLE;
          w_y_n     = C_Y0;
          w_vel_n   = '0;
          w_pend_n  = 1'b0;
        end
      end
`ifdef BIRD_PAUSE_EN
      ST_PAUSE: begin
        if (start) w_state_n = ST_PLAY;
      end
`endif
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign bird_y    = r_y;
  assign state     = r_state;
  assign game_over = (r_state == ST_DEAD);
  assign score     = r_score;

endmodule
